xy_route_unit: RTL and testbench

XY_ROUTE_UNIT -- requirements
Module: xy_route_unit

---
 rtl/xy_route_unit.sv | 167 ++++++++++++++++
 tb/tb_xy_route_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_route_unit.sv
// Single-input XY route unit: a small flit FIFO feeding a packet FSM that latches
// the dimension-ordered route of each head flit and counts completed packets.
module xy_route_unit #(
  parameter int unsigned X_NODE_NUM = 4,
  parameter int unsigned Y_NODE_NUM = 4,
  parameter int unsigned X_W        = 2,
  parameter int unsigned Y_W        = 2,
  parameter int unsigned CUR_X      = 0,
  parameter int unsigned CUR_Y      = 0,
  parameter int unsigned FLIT_W     = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_port,
  output logic [4:0]        out_req,
  output logic              err,
  output logic [15:0]       pkt_cnt
);

  localparam int unsigned  AW       = $clog2(DEPTH);
  localparam logic [AW:0]  LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [X_W-1:0] LP_CUR_X = X_W'(CUR_X);
  localparam logic [Y_W-1:0] LP_CUR_Y = Y_W'(CUR_Y);

  localparam logic [2:0] P_NONE  = 3'd0;
  localparam logic [2:0] P_LOCAL = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;
  localparam logic [2:0] P_SOUTH = 3'd5;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  state_t            r_state;
  logic [2:0]        r_out_port;
  logic [4:0]        r_out_req;
  logic              r_err;
  logic [15:0]       r_pkt_cnt;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [FLIT_W-1:0] w_front;
  logic              w_is_start;
  logic              w_is_end;
  logic [X_W-1:0]    w_dest_x;
  logic [Y_W-1:0]    w_dest_y;
  logic signed [X_W:0] w_dx;
  logic signed [Y_W:0] w_dy;
  logic              w_addr_err;
  logic [2:0]        w_route;

  function automatic logic [4:0] port_to_req(input logic [2:0] p);
    case (p)
      P_LOCAL: return 5'b00001;
      P_EAST:  return 5'b00010;
      P_WEST:  return 5'b00100;
      P_SOUTH: return 5'b01000;
      P_NORTH: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LP_DEPTH);
  assign w_front    = r_mem[r_rptr];
  // type field: bit1 set for head/single (opens a packet), bit0 set for tail/single
  assign w_is_start = w_front[FLIT_W-1];
  assign w_is_end   = w_front[FLIT_W-2];

  assign w_push = in_valid && !w_full;
  assign w_pop  = !w_empty && (((r_state == S_IDLE) && !w_is_start) ||
                               ((r_state == S_ACTIVE) && out_ready));

  assign w_dest_x   = w_front[X_W-1:0];
  assign w_dest_y   = w_front[X_W+Y_W-1:X_W];
  assign w_dx       = $signed({1'b0, w_dest_x}) - $signed({1'b0, LP_CUR_X});
  assign w_dy       = $signed({1'b0, w_dest_y}) - $signed({1'b0, LP_CUR_Y});
  assign w_addr_err = (32'(w_dest_x) >= X_NODE_NUM) || (32'(w_dest_y) >= Y_NODE_NUM);

  always_comb begin
    w_route = P_LOCAL;
    if (!w_addr_err) begin
      if (!w_dx[X_W] && (w_dx != '0))      w_route = P_EAST;
      else if (w_dx[X_W])                  w_route = P_WEST;
      else if (!w_dy[Y_W] && (w_dy != '0)) w_route = P_SOUTH;
      else if (w_dy[Y_W])                  w_route = P_NORTH;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_out_port <= P_NONE;
      r_out_req  <= '0;
      r_err      <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_is_start) begin
              r_state    <= S_ACTIVE;
              r_out_port <= w_route;
              r_out_req  <= port_to_req(w_route);
              r_err      <= w_addr_err;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (w_pop) begin
            if (w_is_end) begin
              r_state    <= S_IDLE;
              r_out_port <= P_NONE;
              r_out_req  <= '0;
              r_pkt_cnt  <= r_pkt_cnt + 16'd1;
            end else if (w_is_start) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign out_flit  = w_front;
  assign out_valid = (r_state == S_ACTIVE) && !w_empty;
  assign out_port  = r_out_port;
  assign out_req   = r_out_req;
  assign err       = r_err;
  assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_xy_route_unit.sv
// Bench for xy_route_unit: three configurations checked each cycle against a
// queue-style packet model, plus directed scenarios with literal expectations.
module tb_xy_route_unit;

  localparam int DEPTH = 4;
  localparam logic [1:0] T_HEAD = 2'b10, T_BODY = 2'b00, T_TAIL = 2'b01, T_SINGLE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_flit   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [7:0]  out_flit  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [2:0]  out_port  [3];
  logic [4:0]  out_req   [3];
  logic        err       [3];
  logic [15:0] pkt_cnt   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xy_route_unit #(.X_NODE_NUM(4), .Y_NODE_NUM(4), .X_W(2), .Y_W(2), .CUR_X(0), .CUR_Y(0),
                  .FLIT_W(8), .DEPTH(DEPTH)) u0 (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_flit(out_flit[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_port(out_port[0]), .out_req(out_req[0]), .err(err[0]), .pkt_cnt(pkt_cnt[0]));

  xy_route_unit #(.X_NODE_NUM(4), .Y_NODE_NUM(4), .X_W(2), .Y_W(2), .CUR_X(1), .CUR_Y(1),
                  .FLIT_W(8), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_flit(out_flit[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_port(out_port[1]), .out_req(out_req[1]), .err(err[1]), .pkt_cnt(pkt_cnt[1]));

  xy_route_unit #(.X_NODE_NUM(3), .Y_NODE_NUM(4), .X_W(2), .Y_W(2), .CUR_X(0), .CUR_Y(0),
                  .FLIT_W(8), .DEPTH(DEPTH)) u2 (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_flit(out_flit[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_port(out_port[2]), .out_req(out_req[2]), .err(err[2]), .pkt_cnt(pkt_cnt[2]));

  function automatic int cfg_cx(input int i); return (i == 1) ? 1 : 0; endfunction
  function automatic int cfg_cy(input int i); return (i == 1) ? 1 : 0; endfunction
  function automatic int cfg_xn(input int i); return (i == 2) ? 3 : 4; endfunction

  function automatic logic [7:0] mk(input logic [1:0] t, input int y, input int x, input logic [1:0] pl);
    return {t, pl, 2'(y), 2'(x)};
  endfunction

  function automatic bit m_bad_addr(input int i, input logic [7:0] f);
    return (int'(f[1:0]) >= cfg_xn(i)) || (int'(f[3:2]) >= 4);
  endfunction

  // Dimension-ordered routing from plain coordinate comparisons.
  function automatic logic [2:0] m_route(input int i, input logic [7:0] f);
    int x, y;
    x = int'(f[1:0]);
    y = int'(f[3:2]);
    if (m_bad_addr(i, f)) return 3'd1;
    if (x > cfg_cx(i)) return 3'd2;
    if (x < cfg_cx(i)) return 3'd4;
    if (y > cfg_cy(i)) return 3'd5;
    if (y < cfg_cy(i)) return 3'd3;
    return 3'd1;
  endfunction

  function automatic logic [4:0] m_req(input logic [2:0] p);
    case (p)
      3'd1: return 5'b00001;
      3'd2: return 5'b00010;
      3'd3: return 5'b10000;
      3'd4: return 5'b00100;
      3'd5: return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: buffered flits in arrival order, packet-open flag, latched route.
  logic [7:0]  m_buf [3][DEPTH];
  int          m_n   [3];
  bit          m_act [3];
  logic [2:0]  m_port[3];
  bit          m_err [3];
  logic [15:0] m_cnt [3];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] b [DEPTH];
    int n;
    bit act, e, pop, push;
    logic [2:0] port;
    logic [1:0] t;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_n[i] <= 0; m_act[i] <= 1'b0; m_port[i] <= 3'd0; m_err[i] <= 1'b0; m_cnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        b = m_buf[i]; n = m_n[i]; act = m_act[i]; port = m_port[i];
        e = 1'b0; pop = 1'b0;
        push = in_valid[i] && (n < DEPTH);
        t = b[0][7:6];
        if (!act) begin
          if (n > 0) begin
            if (t == T_HEAD || t == T_SINGLE) begin
              act = 1'b1; port = m_route(i, b[0]); e = m_bad_addr(i, b[0]);
            end else begin
              pop = 1'b1; e = 1'b1;
            end
          end
        end else if (n > 0 && out_ready[i]) begin
          pop = 1'b1;
          if (t == T_TAIL || t == T_SINGLE) begin
            act = 1'b0; port = 3'd0; m_cnt[i] <= m_cnt[i] + 16'd1;
          end else if (t == T_HEAD) begin
            e = 1'b1;
          end
        end
        if (pop) begin
          for (int k = 0; k < DEPTH - 1; k++) b[k] = b[k+1];
          n--;
        end
        if (push) begin
          b[n] = in_flit[i];
          n++;
        end
        m_buf[i] <= b; m_n[i] <= n; m_act[i] <= act; m_port[i] <= port; m_err[i] <= e;
      end
    end
  end

  logic [7:0] seen_f0[$];
  logic [2:0] seen_p0[$];
  logic [2:0] seen_p1[$];
  logic [4:0] seen_r1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d in_ready", i), 32'(in_ready[i]), 32'(m_n[i] < DEPTH));
      chk($sformatf("u%0d out_valid", i), 32'(out_valid[i]), 32'(m_act[i] && m_n[i] > 0));
      if (m_act[i] && m_n[i] > 0)
        chk($sformatf("u%0d out_flit", i), 32'(out_flit[i]), 32'(m_buf[i][0]));
      chk($sformatf("u%0d out_port", i), 32'(out_port[i]), 32'(m_port[i]));
      chk($sformatf("u%0d out_req", i), 32'(out_req[i]), 32'(m_req(m_port[i])));
      chk($sformatf("u%0d err", i), 32'(err[i]), 32'(m_err[i]));
      chk($sformatf("u%0d pkt_cnt", i), 32'(pkt_cnt[i]), 32'(m_cnt[i]));
    end
    if (out_valid[0] && out_ready[0]) begin
      seen_f0.push_back(out_flit[0]);
      seen_p0.push_back(out_port[0]);
    end
    if (out_valid[1] && out_ready[1]) begin
      seen_p1.push_back(out_port[1]);
      seen_r1.push_back(out_req[1]);
    end
  end

  task automatic send(input int i, input logic [7:0] f);
    int g;
    g = 0;
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_flit[i]  = f;
    while (!in_ready[i] && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("u%0d send_ready", i), 32'(in_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_pkt(input int i, input int target);
    int g;
    g = 0;
    while (int'(pkt_cnt[i]) != target && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("u%0d wait_pkt", i), 32'(pkt_cnt[i]), 32'(target));
  endtask

  initial begin
    logic [2:0] exp_p [4];
    logic [4:0] exp_r [4];
    logic [7:0] pk    [5];
    int g;
    exp_p = '{3'd3, 3'd5, 3'd4, 3'd1};
    exp_r = '{5'b10000, 5'b01000, 5'b00100, 5'b00001};
    pk    = '{mk(T_HEAD, 1, 2, 2'd0), 8'h11, 8'h22, 8'h33, 8'h3C};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_flit[i] = 8'h00; out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst out_port", 32'(out_port[0]), 32'd0);
    chk("rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst pkt_cnt", 32'(pkt_cnt[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single flit east with one-cycle routing latency.
    send(0, mk(T_SINGLE, 1, 2, 2'd1));
    chk("r030 valid_k", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    chk("r030 valid_k1", 32'(out_valid[0]), 32'd1);
    chk("r030 port", 32'(out_port[0]), 32'd2);
    chk("r030 req", 32'(out_req[0]), 32'b00010);
    wait_pkt(0, 1);

    // Four directions from the interior node (1,1).
    send(1, mk(T_SINGLE, 0, 1, 2'd0));
    send(1, mk(T_SINGLE, 2, 1, 2'd1));
    send(1, mk(T_SINGLE, 1, 0, 2'd2));
    send(1, mk(T_SINGLE, 1, 1, 2'd3));
    wait_pkt(1, 4);
    chk("r031 n", 32'(seen_p1.size()), 32'd4);
    for (int k = 0; k < 4 && k < seen_p1.size(); k++) begin
      chk($sformatf("r031 port%0d", k), 32'(seen_p1[k]), 32'(exp_p[k]));
      chk($sformatf("r031 req%0d", k), 32'(seen_r1[k]), 32'(exp_r[k]));
    end

    // Orphan body flit while idle is dropped with an error pulse.
    send(1, mk(T_BODY, 0, 0, 2'd2));
    chk("r033 err_k", 32'(err[1]), 32'd0);
    @(posedge clk); #1;
    chk("r033 err_k1", 32'(err[1]), 32'd1);
    chk("r033 valid_k1", 32'(out_valid[1]), 32'd0);
    @(posedge clk); #1;
    chk("r033 err_k2", 32'(err[1]), 32'd0);
    chk("r033 valid_k2", 32'(out_valid[1]), 32'd0);
    chk("r033 cnt", 32'(pkt_cnt[1]), 32'd4);

    // Out-of-mesh x address falls back to local with an error.
    send(2, mk(T_SINGLE, 0, 3, 2'd0));
    @(posedge clk); #1;
    chk("r035 err", 32'(err[2]), 32'd1);
    chk("r035 port", 32'(out_port[2]), 32'd1);
    wait_pkt(2, 1);

    // Backpressure: head plus four bodies through a 4-deep buffer.
    seen_f0.delete();
    seen_p0.delete();
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, pk[k]);
    chk("r032 full", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("r032 hold", 32'(seen_f0.size()), 32'd0);
    out_ready[0] = 1'b1;
    send(0, pk[4]);
    g = 0;
    while (seen_f0.size() < 5 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("r032 n", 32'(seen_f0.size()), 32'd5);
    for (int k = 0; k < 5 && k < seen_f0.size(); k++) begin
      chk($sformatf("r032 flit%0d", k), 32'(seen_f0[k]), 32'(pk[k]));
      chk($sformatf("r032 port%0d", k), 32'(seen_p0[k]), 32'd2);
    end

    // Reset in the middle of the still-open packet.
    @(posedge clk); #1;
    chk("r034 pre_port", 32'(out_port[0]), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("r034 rst_port", 32'(out_port[0]), 32'd0);
    chk("r034 rst_req", 32'(out_req[0]), 32'd0);
    chk("r034 rst_cnt", 32'(pkt_cnt[0]), 32'd0);
    chk("r034 rst_ready", 32'(in_ready[0]), 32'd1);
    chk("r034 rst_valid", 32'(out_valid[0]), 32'd0);
    chk("r034 rst_err", 32'(err[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, mk(T_SINGLE, 0, 0, 2'd3));
    @(posedge clk); #1;
    chk("r034 port", 32'(out_port[0]), 32'd1);
    chk("r034 req", 32'(out_req[0]), 32'b00001);
    wait_pkt(0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
